mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 111 +++++++++++
 tb/tb_mem_access.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage controller: turns an execute-stage result into a single
// request/acknowledge bus transaction with alignment checking and a timeout.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int WIDTH   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             done,
  output logic             error,
  output logic             busy,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_misaligned;
  logic w_last_cycle;

  assign w_misaligned = (address[2:0] != 3'b000);
  assign w_last_cycle = (r_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every output is a flop updated with non-blocking assignments, so all
  // decisions below read the pre-edge state; the datapath registers share the
  // async reset because the bus must present zeros while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      read_data <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            bus_addr  <= address;
            bus_wdata <= write_data;
            busy      <= 1'b1;
            if (!mem_read && !mem_write) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else if ((mem_read && mem_write) || w_misaligned) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end else begin
              r_state <= S_REQ;
              bus_req <= 1'b1;
              bus_we  <= mem_write;
              r_cnt   <= '0;
            end
          end
        end

        // An ack in the final counted cycle is checked first, so it beats the timeout.
        S_REQ: begin
          if (bus_ack) begin
            r_state <= S_DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (!bus_we) read_data <= bus_rdata;
          end else if (w_last_cycle) begin
            r_state <= S_ERR;
            bus_req <= 1'b0;
            error   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a table of single transactions plus
// hand-written sequences for start-while-busy, stray acks and mid-request reset.
module tb_mem_access;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic             done;
  logic             error;
  logic             busy;
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_ack;
  logic [WIDTH-1:0] bus_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_access #(.TIMEOUT(16), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .done       (done),
    .error      (error),
    .busy       (busy),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          ack_at;     // index of the bus_req cycle carrying ack, -1 = never
    logic [63:0] rdata;
    int          req_cycles;
    logic        exp_done;
    logic        exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   reqc;
    logic stable;
    start      = 1'b1;
    mem_read   = v.rd;
    mem_write  = v.wr;
    address    = v.addr;
    write_data = v.wdata;
    tick();
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '1;
    write_data = '1;
    check({v.name, " bus_addr"},  bus_addr,  v.addr);
    check({v.name, " bus_wdata"}, bus_wdata, v.wdata);
    reqc   = 0;
    stable = 1'b1;
    while (bus_req && reqc < 100) begin
      if (bus_we !== v.wr || bus_addr !== v.addr || bus_wdata !== v.wdata) stable = 1'b0;
      if (reqc == v.ack_at) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
      end
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      reqc++;
    end
    check({v.name, " req_cycles"}, 64'(reqc), 64'(v.req_cycles));
    check({v.name, " bus_stable"}, {63'd0, stable}, 64'd1);
    check({v.name, " done"},  {63'd0, done},  {63'd0, v.exp_done});
    check({v.name, " error"}, {63'd0, error}, {63'd0, v.exp_err});
    check({v.name, " busy"},  {63'd0, busy},  64'd1);
    check({v.name, " bus_req_low"}, {63'd0, bus_req}, 64'd0);
    check({v.name, " read_data"}, read_data, v.exp_rd);
    tick();
    check({v.name, " pulse_end"}, {62'd0, done, error}, 64'd0);
    check({v.name, " busy_low"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flags"}, {59'd0, done, error, busy, bus_req, bus_we}, 64'd0);
    check({tag, " bus_addr"},  bus_addr,  64'd0);
    check({tag, " bus_wdata"}, bus_wdata, 64'd0);
    check({tag, " read_data"}, read_data, 64'd0);
  endtask

  initial begin
    vecs[0] = '{"read_ack3",    1'b1, 1'b0, 64'h40,  64'h0,    2, 64'hDEADBEEF,            3, 1'b1, 1'b0, 64'hDEADBEEF};
    vecs[1] = '{"store_imm",    1'b0, 1'b1, 64'h08,  64'h1234, 0, 64'hBAD0BAD0,            1, 1'b1, 1'b0, 64'hDEADBEEF};
    vecs[2] = '{"misaligned",   1'b1, 1'b0, 64'h0C,  64'h0,    0, 64'h1111,                0, 1'b0, 1'b1, 64'hDEADBEEF};
    vecs[3] = '{"both_flags",   1'b1, 1'b1, 64'h10,  64'h77,   0, 64'h2222,                0, 1'b0, 1'b1, 64'hDEADBEEF};
    vecs[4] = '{"passthrough",  1'b0, 1'b0, 64'h03,  64'h99,   0, 64'h3333,                0, 1'b1, 1'b0, 64'hDEADBEEF};
    vecs[5] = '{"timeout",      1'b1, 1'b0, 64'h100, 64'h0,   -1, 64'h4444,               16, 1'b0, 1'b1, 64'hDEADBEEF};
    vecs[6] = '{"ack_last",     1'b1, 1'b0, 64'h200, 64'h0,   15, 64'h0123456789ABCDEF,   16, 1'b1, 1'b0, 64'h0123456789ABCDEF};
    vecs[7] = '{"write_timeout",1'b0, 1'b1, 64'h18,  64'hFACE,-1, 64'h5555,               16, 1'b0, 1'b1, 64'h0123456789ABCDEF};
    vecs[8] = '{"read_ack14",   1'b1, 1'b0, 64'hFF8, 64'h0,   14, 64'hA5A5000011112222,   15, 1'b1, 1'b0, 64'hA5A5000011112222};

    reset      = 1'b1;
    start      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Stray ack while idle must not load read_data or pulse done.
    bus_ack   = 1'b1;
    bus_rdata = 64'hFFFF_0000_FFFF_0000;
    tick();
    tick();
    bus_ack = 1'b0;
    check("idle_ack read_data", read_data, 64'hA5A5000011112222);
    check("idle_ack done_req", {62'd0, done, bus_req}, 64'd0);

    // Start held high during REQ and DONE is ignored.
    start     = 1'b1;
    mem_read  = 1'b1;
    address   = 64'h28;
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b1;
    address   = 64'h80;
    tick();
    tick();
    check("busy_start bus_addr", bus_addr, 64'h28);
    check("busy_start bus_we", {63'd0, bus_we}, 64'd0);
    check("busy_start bus_req", {63'd0, bus_req}, 64'd1);
    bus_ack   = 1'b1;
    bus_rdata = 64'hCAFE;
    tick();
    bus_ack = 1'b0;
    check("busy_start done", {63'd0, done}, 64'd1);
    check("busy_start read_data", read_data, 64'hCAFE);
    tick();
    start     = 1'b0;
    mem_write = 1'b0;
    check("busy_start idle", {62'd0, busy, bus_req}, 64'd0);
    tick();
    check("busy_start no_retrigger", {61'd0, busy, bus_req, done}, 64'd0);

    // Reset in the middle of a request abandons it immediately.
    start     = 1'b1;
    mem_read  = 1'b1;
    address   = 64'h40;
    tick();
    start    = 1'b0;
    mem_read = 1'b0;
    tick();
    check("pre_reset bus_req", {63'd0, bus_req}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("post_reset");

    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
